// File: rtl/sp_ram_obi_pkg.sv
// Shared widths and types for the OBI single-port RAM.
package sp_ram_obi_pkg;

    localparam int unsigned SP_RAM_ADDR_WIDTH = 14;
    localparam int unsigned SP_RAM_DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH          = SP_RAM_DATA_WIDTH / 8;

    typedef logic [SP_RAM_DATA_WIDTH-1:0] word_t;
    typedef logic [BE_WIDTH-1:0]          be_t;

endpackage

// File: rtl/sp_ram_core.sv
// Byte-writable synchronous RAM with a registered read, written to infer block RAM.
module sp_ram_core
    import sp_ram_obi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SP_RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SP_RAM_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Read returns the word as it was before a same-edge write (read-first).
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int n = 0; n < DATA_WIDTH / 8; n++) begin
                    if (be[n]) begin
                        mem[addr][8*n +: 8] <= wdata[8*n +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/obi_sp_ram.sv
// OBI subordinate wrapper around sp_ram_core: zero-wait grant, one-cycle response.
// Define SP_RAM_OBI_ASSERT_EN to compile in simulation-only protocol assertions.
module obi_sp_ram
    import sp_ram_obi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SP_RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SP_RAM_DATA_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [31:0]               addr_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      rvalid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    logic                  accept;
    logic                  rvalid_q;
    logic                  read_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  unused_addr;

    assign accept      = req_i & ~rst_i;
    assign gnt_o       = accept;
    // Upper bits alias the array across the address space; low bits are covered by be_i.
    assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

    sp_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk   (clk_i),
        .en    (accept),
        .we    (we_i),
        .be    (be_i),
        .addr  (addr_i[ADDR_WIDTH+1:2]),
        .wdata (wdata_i),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            read_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            rvalid_q <= accept;
            read_q   <= accept & ~we_i;
            hold_q   <= rdata_o;
        end
    end

    // hold_q keeps rdata_o stable between responses; everything here is registered.
    always_comb begin
        rdata_o = hold_q;
        if (rvalid_q) begin
            rdata_o = read_q ? core_rdata : '0;
        end
    end

    assign rvalid_o = rvalid_q;

`ifdef SP_RAM_OBI_ASSERT_EN
    logic seen_accept_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seen_accept_q <= 1'b0;
        end else if (accept) begin
            seen_accept_q <= 1'b1;
        end
    end

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("obi_sp_ram supports DATA_WIDTH == 32 only");
    end

    a_req_known : assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown(req_i));
    a_ctrl_known : assert property (@(posedge clk_i) disable iff (rst_i)
        req_i |-> !$isunknown({addr_i, we_i}));
    a_wr_known : assert property (@(posedge clk_i) disable iff (rst_i)
        (req_i && we_i) |-> !$isunknown({be_i, wdata_i}));
    a_no_spurious_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
        rvalid_o |-> seen_accept_q);
`endif

endmodule

// File: tb/tb_obi_sp_ram.sv
// Directed bench for obi_sp_ram with a scoreboard of per-cycle response expectations.
module tb_obi_sp_ram;
    import sp_ram_obi_pkg::*;

    typedef struct {
        logic  rvalid;
        word_t rdata;
        string tag;
    } exp_t;

    logic  clk_i = 1'b0;
    logic  rst_i;
    logic  req_i;
    logic  gnt_o;
    logic  [31:0] addr_i;
    logic  we_i;
    be_t   be_i;
    word_t wdata_i;
    logic  rvalid_o;
    word_t rdata_o;

    int    checks = 0;
    int    passed = 0;
    exp_t  sb[$];
    word_t mem_m [int];
    word_t hold_m = '0;

    always #5 clk_i = ~clk_i;

    obi_sp_ram dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus and queue what the response side must show after the edge.
    task automatic step(input string tag, input logic rst, input logic req, input logic we,
                        input logic [31:0] addr, input be_t be, input word_t wdata);
        exp_t  e;
        int    idx;
        word_t w;
        @(negedge clk_i);
        rst_i = rst; req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
        #1;
        chk({tag, " gnt"}, {31'b0, gnt_o}, {31'b0, req & ~rst});
        idx = int'(addr[15:2]);
        e.tag = tag;
        if (req && !rst) begin
            e.rvalid = 1'b1;
            if (we) begin
                e.rdata = '0;
                w = mem_m.exists(idx) ? mem_m[idx] : 'x;
                for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = wdata[8*n +: 8];
                mem_m[idx] = w;
            end else begin
                e.rdata = mem_m.exists(idx) ? mem_m[idx] : 'x;
            end
            hold_m = e.rdata;
        end else if (rst) begin
            e.rvalid = 1'b0;
            e.rdata  = '0;
            hold_m   = '0;
        end else begin
            e.rvalid = 1'b0;
            e.rdata  = hold_m;
        end
        sb.push_back(e);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input word_t d, input be_t be);
        step(tag, 1'b0, 1'b1, 1'b1, a, be, d);
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        step(tag, 1'b0, 1'b1, 1'b0, a, 4'hF, 32'h0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    always @(posedge clk_i) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, " rvalid"}, {31'b0, rvalid_o}, {31'b0, e.rvalid});
            chk({e.tag, " rdata"}, rdata_o, e.rdata);
        end
    end

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        step("por", 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step("por", 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wr("pre_rst_wr", 32'h0000_0500, 32'hA5A5_A5A5, 4'hF);
        for (int i = 0; i < 3; i++)
            step("rst_req", 1'b1, 1'b1, 1'b1, 32'h0000_0500, 4'hF, 32'hFFFF_FFFF);
        rd("rst_no_write", 32'h0000_0500);
        idle("idle_hold");

        wr("wr_1000", 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        rd("rd_1000", 32'h0000_1000);
        idle("idle_hold_rd");
        wr("wr_1004", 32'h0000_1004, 32'hCAFE_BA00, 4'hF);
        rd("rd_1004", 32'h0000_1004);

        wr("be_init", 32'h0000_2000, 32'h0000_0000, 4'hF);
        wr("be_0001", 32'h0000_2000, 32'hFFFF_FFAA, 4'h1);
        wr("be_0100", 32'h0000_2000, 32'hFFBB_FFFF, 4'h4);
        wr("be_none", 32'h0000_2000, 32'h1234_5678, 4'h0);
        rd("rd_be", 32'h0000_2000);

        wr("b2b_3000", 32'h0000_3000, 32'h1111_1111, 4'hF);
        wr("b2b_3004", 32'h0000_3004, 32'h2222_2222, 4'hF);
        wr("b2b_3008", 32'h0000_3008, 32'h3333_3333, 4'hF);
        rd("rd_3000", 32'h0000_3000);
        rd("rd_3004", 32'h0000_3004);
        rd("rd_3008", 32'h0000_3008);
        idle("idle_after_wr");

        wr("wr_0010", 32'h0000_0010, 32'h1234_5678, 4'hF);
        rd("alias_10010", 32'h0001_0010);
        rd("alias_0013", 32'h0000_0013);

        wr("mix_wr", 32'h0000_4000, 32'h0F0F_0F0F, 4'hF);
        rd("mix_rd", 32'h0000_4000);
        wr("mix_wr2", 32'h0000_4000, 32'hF0F0_F0F0, 4'hF);
        rd("mix_rd2", 32'h0000_4000);

        for (int i = 0; i < 4; i++)
            wr("rnd_wr", 32'h0000_5000 + 32'(i * 4), word_t'($urandom), 4'(1 + $urandom_range(0, 14)));
        for (int i = 0; i < 4; i++)
            rd("rnd_rd", 32'h0000_5000 + 32'(i * 4));

        rd("abort_rd", 32'h0000_1000);
        step("abort_rst", 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        idle("post_abort");
        idle("post_abort2");

        @(posedge clk_i);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
